// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor ramp controller: mode codes, per-mode
// target duties, FSM state encoding and the duty step helper.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ESTOP = 2'd3
  } state_t;

  localparam logic [2:0] MODE_STOP       = 3'd0;
  localparam logic [2:0] MODE_FWD        = 3'd1;
  localparam logic [2:0] MODE_SOFT_LEFT  = 3'd2;
  localparam logic [2:0] MODE_SOFT_RIGHT = 3'd3;
  localparam logic [2:0] MODE_HARD_LEFT  = 3'd4;
  localparam logic [2:0] MODE_HARD_RIGHT = 3'd5;
  localparam logic [2:0] MODE_SLOW       = 3'd6;

  localparam logic [9:0] DUTY_OFF  = 10'd0;
  localparam logic [9:0] DUTY_HALF = 10'd256;
  localparam logic [9:0] DUTY_FULL = 10'd511;

  typedef struct packed {
    logic [9:0] left;
    logic [9:0] right;
  } target_t;

  function automatic target_t decode_mode(input logic [2:0] mode);
    target_t t;
    case (mode)
      MODE_FWD:        t = '{left: DUTY_FULL, right: DUTY_FULL};
      MODE_SOFT_LEFT:  t = '{left: DUTY_HALF, right: DUTY_FULL};
      MODE_SOFT_RIGHT: t = '{left: DUTY_FULL, right: DUTY_HALF};
      MODE_HARD_LEFT:  t = '{left: DUTY_OFF,  right: DUTY_FULL};
      MODE_HARD_RIGHT: t = '{left: DUTY_FULL, right: DUTY_OFF};
      MODE_SLOW:       t = '{left: DUTY_HALF, right: DUTY_HALF};
      default:         t = '{left: DUTY_OFF,  right: DUTY_OFF};
    endcase
    return t;
  endfunction

  // One tick of slew toward tgt in 11-bit space, clamped so it never overshoots.
  function automatic logic [9:0] step_duty(input logic [9:0] cur, input logic [9:0] tgt,
                                           input logic [9:0] step, input logic kick,
                                           input logic [9:0] kick_duty);
    logic [10:0] c, t, s, d, r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, step};
    d = 11'd0;
    if (kick && (cur == 10'd0) && (tgt != 10'd0)) begin
      r = (kick_duty < tgt) ? {1'b0, kick_duty} : t;
    end else if (c < t) begin
      d = t - c;
      r = c + ((d < s) ? d : s);
    end else if (c > t) begin
      d = c - t;
      r = c - ((d < s) ? d : s);
    end else begin
      r = c;
    end
    return r[9:0];
  endfunction

endpackage

// File: rtl/motor_ramp_step.sv
// Per-side duty register: holds, steps on tick, or clears to zero.
module motor_ramp_step
  import motor_ctrl_pkg::*;
#(
  parameter int STEP_SIZE = 16,
  parameter int KICK_DUTY = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] duty,
  input  logic [9:0] target,
  input  logic       tick,
  input  logic       kick,
  input  logic       clear,
  output logic [9:0] next_duty
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_duty <= 10'd0;
    end else if (clear) begin
      next_duty <= 10'd0;
    end else if (tick) begin
      next_duty <= step_duty(duty, target, 10'(STEP_SIZE), kick, 10'(KICK_DUTY));
    end else begin
      next_duty <= duty;
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-motor duty sequencer with tick-paced slewing and emergency stop.
// Optional kick-start on leaving IDLE is enabled by defining MOTOR_KICK_EN.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = 100_000,
  parameter int STEP_SIZE   = 16,
  parameter int KICK_DUTY   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       estop,
  output logic [9:0] left_duty,
  output logic [9:0] right_duty,
  output logic [1:0] state,
  output logic       at_target
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  state_t        st;
  target_t       tgt, tgt_next;
  logic [CW-1:0] cnt;
  logic          tick, step_en, clear, both_at, tgt_zero, estop_next, kick_pend;
  logic [9:0]    left_next, right_next;

  assign tick       = (cnt == CNT_LAST);
  assign step_en    = tick && (st == ST_RAMP);
  assign clear      = estop || (st == ST_ESTOP);
  assign tgt_next   = decode_mode(mode);
  assign tgt_zero   = (tgt == '0);
  assign both_at    = (left_duty == tgt.left) && (right_duty == tgt.right);
  assign estop_next = estop || ((st == ST_ESTOP) && !tgt_zero);
  assign state      = st;

  // Look-ahead of the duty registers so at_target lines up with the duties it describes.
  assign left_next  = clear ? 10'd0 : (step_en ? step_duty(left_duty, tgt.left, 10'(STEP_SIZE),
                                                           kick_pend, 10'(KICK_DUTY)) : left_duty);
  assign right_next = clear ? 10'd0 : (step_en ? step_duty(right_duty, tgt.right, 10'(STEP_SIZE),
                                                           kick_pend, 10'(KICK_DUTY)) : right_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      tgt       <= '0;
      cnt       <= '0;
      at_target <= 1'b1;
    end else begin
      tgt       <= tgt_next;
      at_target <= !estop_next && (left_next == tgt_next.left) && (right_next == tgt_next.right);
      cnt       <= tick ? '0 : cnt + CW'(1);
      if (estop) begin
        st <= ST_ESTOP;
      end else begin
        case (st)
          ST_IDLE:  if (!tgt_zero) begin st <= ST_RAMP; cnt <= '0; end
          ST_RAMP:  if (both_at) st <= tgt_zero ? ST_IDLE : ST_HOLD;
          ST_HOLD:  if (!both_at) begin st <= ST_RAMP; cnt <= '0; end
          ST_ESTOP: if (tgt_zero) st <= ST_IDLE;
          default:  st <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MOTOR_KICK_EN
  // Armed only by IDLE -> RAMP; consumed by the first tick or lost on leaving RAMP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kick_pend <= 1'b0;
    end else if ((st == ST_IDLE) && !tgt_zero && !estop) begin
      kick_pend <= 1'b1;
    end else if (step_en || (st != ST_RAMP)) begin
      kick_pend <= 1'b0;
    end
  end
`else
  assign kick_pend = 1'b0;
`endif

  motor_ramp_step #(.STEP_SIZE(STEP_SIZE), .KICK_DUTY(KICK_DUTY)) u_left (
    .clk(clk), .rst(rst), .duty(left_duty), .target(tgt.left), .tick(step_en),
    .kick(kick_pend), .clear(clear), .next_duty(left_duty)
  );

  motor_ramp_step #(.STEP_SIZE(STEP_SIZE), .KICK_DUTY(KICK_DUTY)) u_right (
    .clk(clk), .rst(rst), .duty(right_duty), .target(tgt.right), .tick(step_en),
    .kick(kick_pend), .clear(clear), .next_duty(right_duty)
  );

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: directed scenarios plus random
// mode/estop/reset traffic against a behavioural model (honours MOTOR_KICK_EN).
module tb_motor_ramp_ctrl;

  localparam int SC = 4;
  localparam int SS = 16;
  localparam int KD = 200;
`ifdef MOTOR_KICK_EN
  localparam bit KICK_ON = 1'b1;
`else
  localparam bit KICK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       estop;
  logic [9:0] left_duty, right_duty;
  logic [1:0] state;
  logic       at_target;

  int n_assert = 0;
  int n_fail = 0;

  int tl_tab[8] = '{0, 511, 256, 511, 0, 511, 256, 0};
  int tr_tab[8] = '{0, 511, 511, 256, 511, 0, 256, 0};

  // model: duties, targets, state (0 idle,1 ramp,2 hold,3 estop), cycles since RAMP entry, kick armed
  int ml, mr, mtl, mtr, mst, mph;
  bit mkick;

  motor_ramp_ctrl #(.STEP_CYCLES(SC), .STEP_SIZE(SS), .KICK_DUTY(KD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .estop(estop),
    .left_duty(left_duty), .right_duty(right_duty), .state(state), .at_target(at_target)
  );

  always #5 clk = ~clk;

  function automatic int approach(int cur, int tgt, bit kick);
    if (kick && cur == 0 && tgt != 0) return (KD < tgt) ? KD : tgt;
    if (cur < tgt) return cur + (((tgt - cur) < SS) ? (tgt - cur) : SS);
    if (cur > tgt) return cur - (((cur - tgt) < SS) ? (cur - tgt) : SS);
    return cur;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ml = 0; mr = 0; mtl = 0; mtr = 0; mst = 0; mph = 0; mkick = 1'b0;
  endtask

  task automatic model_edge();
    int nl, nr, nst;
    bit tick, at, zero;
    tick = (mst == 1) && ((mph % SC) == SC - 1);
    at   = (ml == mtl) && (mr == mtr);
    zero = (mtl == 0) && (mtr == 0);
    nl = ml; nr = mr; nst = mst;
    if (estop || mst == 3) begin
      nl = 0; nr = 0;
    end else if (tick) begin
      nl = approach(ml, mtl, mkick);
      nr = approach(mr, mtr, mkick);
    end
    mph++;
    if (tick) mkick = 1'b0;
    if (estop) nst = 3;
    else if (mst == 0 && !zero) begin nst = 1; mph = 0; mkick = KICK_ON; end
    else if (mst == 1 && at) nst = zero ? 0 : 2;
    else if (mst == 2 && !at) begin nst = 1; mph = 0; end
    else if (mst == 3 && zero) nst = 0;
    if (nst != 1) mkick = 1'b0;
    ml = nl; mr = nr; mst = nst;
    mtl = tl_tab[mode]; mtr = tr_tab[mode];
  endtask

  task automatic compare();
    chk("left_duty", int'(left_duty), ml);
    chk("right_duty", int'(right_duty), mr);
    chk("state", int'(state), mst);
    chk("at_target", int'(at_target), (mst != 3 && ml == mtl && mr == mtr) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare();
    chk("rst_async_left", int'(left_duty), 0);
    chk("rst_async_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 3'd0; estop = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare();
    chk("reset_at_target", int'(at_target), 1);
    rst = 1'b0;

    // FWD ramp-up
    mode = 3'd1;
`ifndef MOTOR_KICK_EN
    run(126); chk("fwd_31_ticks", int'(left_duty), 496);
    run(4);   chk("fwd_32_ticks", int'(right_duty), 511);
              chk("fwd_at_target", int'(at_target), 1);
    run(1);   chk("fwd_hold", int'(state), 2);
`else
    run(131); chk("fwd_hold", int'(state), 2);
`endif

    // HOLD -> SOFT_LEFT: left drops 16 per tick, right untouched
    mode = 3'd2;
    run(66); chk("soft_left_256", int'(left_duty), 256);
             chk("soft_left_right", int'(right_duty), 511);
    run(3);  chk("soft_left_hold", int'(state), 2);

    // back to IDLE, then estop mid-ramp
    mode = 3'd0;
    run(140); chk("stop_idle", int'(state), 0);
    mode = 3'd1;
    run(34);
`ifndef MOTOR_KICK_EN
    chk("estop_pre_128", int'(left_duty), 128);
`endif
    estop = 1'b1;
    run(1); chk("estop_duty0", int'(left_duty), 0);
            chk("estop_state", int'(state), 3);
    estop = 1'b0;
    run(5); chk("estop_stay", int'(state), 3);
    mode = 3'd0;
    run(2); chk("estop_exit_idle", int'(state), 0);

    // reserved mode 7 ramps down from full
    mode = 3'd1;
    run(131); chk("fwd2_hold", int'(state), 2);
    mode = 3'd7;
    run(140); chk("mode7_idle", int'(state), 0);
              chk("mode7_at_target", int'(at_target), 1);
              chk("mode7_duty0", int'(right_duty), 0);

    // asynchronous reset mid-ramp
    mode = 3'd1;
    run(20);
    async_reset();
    mode = 3'd0;
    run(2);

`ifdef MOTOR_KICK_EN
    mode = 3'd6;
    run(6);  chk("kick_first", int'(left_duty), 200);
    run(4);  chk("kick_second", int'(right_duty), 216);
    run(30); chk("kick_end", int'(left_duty), 256);
    mode = 3'd0;
    run(60);
`endif

    // randomized traffic
    for (int seg = 0; seg < 50; seg++) begin
      int len, r;
      mode = 3'($urandom_range(0, 7));
      len  = $urandom_range(1, 120);
      r    = $urandom_range(0, 99);
      for (int c = 0; c < len; c++) begin
        estop = (r < 12) && (c >= len / 2) && (c < len / 2 + 3);
        cycle();
      end
      estop = 1'b0;
      if (r >= 95) async_reset();
    end
    estop = 1'b0;
    mode = 3'd0;
    run(200);
    chk("final_idle", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
